// File: rtl/key_pkg.sv
// Shared constants for the push-button conditioning block.
package key_pkg;

    localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 1000000;
    localparam int unsigned SIM_DEBOUNCE_CYCLES     = 8;
    localparam int unsigned DEFAULT_CNT_W           = 20;
    localparam logic        KEY_RELEASED            = 1'b1;

endpackage

// File: rtl/key_debounce_chan.sv
// One key channel: 2-FF synchronizer, counter debouncer, edge pulses and sticky press latch.
module key_debounce_chan
    import key_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int unsigned CNT_W           = DEFAULT_CNT_W
) (
    input  logic clk,
    input  logic reset_n,
    input  logic key_raw,
    input  logic clr_hit,
    output logic key_db,
    output logic press_pulse,
    output logic release_pulse,
    output logic press_latch
);

    localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1;
    logic             sync2;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             key_db_nxt;
    logic             press_nxt;
    logic             release_nxt;
    logic             latch_nxt;

    // Count while the synchronized input disagrees with the stable level; accept at terminal count.
    always_comb begin
        cnt_nxt     = '0;
        key_db_nxt  = key_db;
        press_nxt   = 1'b0;
        release_nxt = 1'b0;
        if (sync2 != key_db) begin
            if (cnt == CNT_TERM) begin
                key_db_nxt  = sync2;
                press_nxt   = (sync2 != KEY_RELEASED);
                release_nxt = (sync2 == KEY_RELEASED);
            end else begin
                cnt_nxt = cnt + CNT_W'(1);
            end
        end
    end

    // A press in flight beats a coincident clear so no press is lost.
    always_comb begin
        latch_nxt = press_latch;
        if (press_pulse) begin
            latch_nxt = 1'b1;
        end else if (clr_hit) begin
            latch_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1         <= KEY_RELEASED;
            sync2         <= KEY_RELEASED;
            cnt           <= '0;
            key_db        <= KEY_RELEASED;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            press_latch   <= 1'b0;
        end else begin
            sync1         <= key_raw;
            sync2         <= sync1;
            cnt           <= cnt_nxt;
            key_db        <= key_db_nxt;
            press_pulse   <= press_nxt;
            release_pulse <= release_nxt;
            press_latch   <= latch_nxt;
        end
    end

endmodule

// File: rtl/key_debounce_sync.sv
// Conditions raw active-low push buttons for the key PIO: per-key debounce, pulses and press capture.
module key_debounce_sync
    import key_pkg::*;
#(
    parameter int unsigned NUM_KEYS        = 4,
    parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int unsigned CNT_W           = DEFAULT_CNT_W
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [NUM_KEYS-1:0] key_raw,
    output logic [NUM_KEYS-1:0] key_db,
    output logic [NUM_KEYS-1:0] press_pulse,
    output logic [NUM_KEYS-1:0] release_pulse,
    output logic [NUM_KEYS-1:0] press_latch,
    input  logic                clr,
    input  logic [NUM_KEYS-1:0] clr_mask
);

    for (genvar i = 0; i < int'(NUM_KEYS); i++) begin : g_chan
        key_debounce_chan #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W)
        ) u_chan (
            .clk           (clk),
            .reset_n       (reset_n),
            .key_raw       (key_raw[i]),
            .clr_hit       (clr & clr_mask[i]),
            .key_db        (key_db[i]),
            .press_pulse   (press_pulse[i]),
            .release_pulse (release_pulse[i]),
            .press_latch   (press_latch[i])
        );
    end

endmodule

// File: tb/tb_key_debounce_sync.sv
// Directed bench for key_debounce_sync with an 8-cycle debounce window.
module tb_key_debounce_sync;
    import key_pkg::*;

    localparam int unsigned NK = 4;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [NK-1:0] key_raw;
    logic [NK-1:0] key_db;
    logic [NK-1:0] press_pulse;
    logic [NK-1:0] release_pulse;
    logic [NK-1:0] press_latch;
    logic          clr;
    logic [NK-1:0] clr_mask;

    int checks   = 0;
    int failures = 0;
    int pcnt [NK];
    int rcnt [NK];

    key_debounce_sync #(
        .NUM_KEYS        (NK),
        .DEBOUNCE_CYCLES (SIM_DEBOUNCE_CYCLES),
        .CNT_W           (20)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .key_raw       (key_raw),
        .key_db        (key_db),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse),
        .press_latch   (press_latch),
        .clr           (clr),
        .clr_mask      (clr_mask)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Advance one clock and sample 1 time unit after the edge; tally pulses per key.
    task automatic tick();
        @(posedge clk);
        #1;
        for (int i = 0; i < int'(NK); i++) begin
            if (press_pulse[i])   pcnt[i]++;
            if (release_pulse[i]) rcnt[i]++;
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic clear_counts();
        for (int i = 0; i < int'(NK); i++) begin
            pcnt[i] = 0;
            rcnt[i] = 0;
        end
    endtask

    task automatic do_clr(input logic [NK-1:0] m);
        clr      = 1'b1;
        clr_mask = m;
        tick();
        clr      = 1'b0;
        clr_mask = '0;
    endtask

    initial begin
        reset_n  = 1'b0;
        key_raw  = 4'b0000;
        clr      = 1'b0;
        clr_mask = '0;
        clear_counts();

        // 1. Reset state with all keys held, then re-debounce after release.
        #23;
        check("rst_key_db", 32'(key_db), 32'h0000000f);
        check("rst_pulses", 32'({press_pulse, release_pulse}), 32'h0);
        check("rst_latch", 32'(press_latch), 32'h0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        ticks(9);
        check("rst_pre_pulse", 32'(press_pulse), 32'h0);
        check("rst_pre_db", 32'(key_db), 32'h0000000f);
        tick();
        check("rst_press_pulse", 32'(press_pulse), 32'h0000000f);
        check("rst_key_db_held", 32'(key_db), 32'h0);
        tick();
        check("rst_pulse_one_cycle", 32'(press_pulse), 32'h0);
        check("rst_latch_set", 32'(press_latch), 32'h0000000f);
        do_clr(4'b1111);
        check("rst_latch_clr_all", 32'(press_latch), 32'h0);
        key_raw = 4'b1111;
        ticks(12);
        check("rst_all_released", 32'(key_db), 32'h0000000f);

        // 2. Clean press and release on key 0.
        clear_counts();
        key_raw = 4'b1110;
        ticks(9);
        check("press0_early", 32'(press_pulse), 32'h0);
        tick();
        check("press0_pulse", 32'(press_pulse), 32'h1);
        check("press0_db", 32'(key_db), 32'he);
        tick();
        check("press0_pulse_off", 32'(press_pulse), 32'h0);
        check("press0_latch", 32'(press_latch), 32'h1);
        key_raw = 4'b1111;
        ticks(9);
        check("rel0_early", 32'(release_pulse), 32'h0);
        tick();
        check("rel0_pulse", 32'(release_pulse), 32'h1);
        check("rel0_db", 32'(key_db), 32'hf);
        tick();
        check("rel0_pulse_off", 32'(release_pulse), 32'h0);

        // 3. Bounce on key 1: low 5, high 1, low 20.
        clear_counts();
        key_raw = 4'b1101;
        ticks(5);
        key_raw = 4'b1111;
        tick();
        key_raw = 4'b1101;
        ticks(9);
        check("bounce_no_early_pulse", 32'(pcnt[1]), 32'h0);
        tick();
        check("bounce_pulse", 32'(press_pulse), 32'h2);
        ticks(10);
        check("bounce_one_pulse", 32'(pcnt[1]), 32'h1);
        key_raw = 4'b1111;
        ticks(12);

        // 4. Clear handshake.
        check("clr_latch_before", 32'(press_latch), 32'h3);
        do_clr(4'b0001);
        check("clr_mask1", 32'(press_latch), 32'h2);
        do_clr(4'b0000);
        check("clr_mask0_noop", 32'(press_latch), 32'h2);

        // 5. Clear aimed at key 2 while its press pulse is high.
        key_raw = 4'b1011;
        ticks(10);
        check("coll_pulse", 32'(press_pulse), 32'h4);
        do_clr(4'b0100);
        check("coll_set_wins", 32'(press_latch), 32'h6);
        tick();
        check("coll_latch_hold", 32'(press_latch), 32'h6);
        key_raw = 4'b1111;
        ticks(12);

        // 6. Simultaneous keys 2 and 3, then reset mid-count.
        do_clr(4'b1111);
        clear_counts();
        key_raw = 4'b0011;
        ticks(9);
        check("simul_early", 32'(press_pulse), 32'h0);
        tick();
        check("simul_pulse", 32'(press_pulse), 32'hc);
        tick();
        check("simul_once", 32'(pcnt[2] + pcnt[3]), 32'h2);
        check("simul_latch", 32'(press_latch), 32'hc);
        key_raw = 4'b1111;
        ticks(12);
        key_raw = 4'b1110;
        ticks(7);
        reset_n = 1'b0;
        #1;
        check("midrst_db", 32'(key_db), 32'hf);
        check("midrst_latch", 32'(press_latch), 32'h0);
        key_raw = 4'b1111;
        tick();
        clear_counts();
        reset_n = 1'b1;
        ticks(15);
        check("midrst_no_stale", 32'(pcnt[0] + pcnt[1] + pcnt[2] + pcnt[3]), 32'h0);
        check("midrst_db_after", 32'(key_db), 32'hf);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/key_debounce_sync.md
Name: key_debounce_sync

Overview:
Conditions raw push-button inputs before they reach the key PIO Avalon slave's in_port. Per key:
- 2-FF synchronizer into clk, then a counter-based debouncer.
- Debounced level output with the same polarity as the pins (1 = released, 0 = pressed), so PIO software reads are unchanged.
- Single-cycle press/release pulses.
- A sticky press-capture register with a clear handshake, used by the interrupt/poll logic.

Parameters:
- NUM_KEYS, 4, number of independent key channels.
- DEBOUNCE_CYCLES, 1000000, cycles the synchronized input must differ from the stable state before the stable state changes (20 ms at 50 MHz); legal range 2..2^CNT_W.
- CNT_W, 20, debounce counter width.

Ports:
- clk  in  1  system clock (same clock as the PIO slave).
- reset_n  in  1  asynchronous, active-low reset.
- key_raw  in  NUM_KEYS  asynchronous button pins, active-low (0 = pressed).
- key_db  out  NUM_KEYS  debounced level, active-low; drives PIO in_port.
- press_pulse  out  NUM_KEYS  1-cycle pulse when key_db bit goes 1->0.
- release_pulse  out  NUM_KEYS  1-cycle pulse when key_db bit goes 0->1.
- press_latch  out  NUM_KEYS  sticky; set by press_pulse, cleared by clr.
- clr  in  1  strobe; clears press_latch bits selected by clr_mask.
- clr_mask  in  NUM_KEYS  bit mask qualifying clr.

Behaviour:
- Reset is asynchronous (reset_n low), all outputs registered:
  - sync stages = all 1s; key_db = all 1s (released); counters = 0.
  - press_pulse = release_pulse = press_latch = 0.
- Synchronizer: two flops per key, no logic between them. sync2 is the debouncer input.
- Debounce, per key, each cycle:
  - sync2 == key_db: counter <= 0.
  - sync2 != key_db and counter != DEBOUNCE_CYCLES-1: counter <= counter+1.
  - sync2 != key_db and counter == DEBOUNCE_CYCLES-1: key_db <= sync2, counter <= 0, matching pulse asserted that same cycle (registered alongside key_db).
  - Any glitch that returns sync2 to key_db before terminal count restarts the count from 0. There is no partial credit.
- Latency: a clean edge on key_raw reaches key_db DEBOUNCE_CYCLES+2 cycles after the first sampling edge.
- Pulses: exactly one cycle high per accepted transition. Never both press and release for the same key in the same cycle.
- press_latch[i], next state:
  - press_pulse[i]: 1 (set wins over a simultaneous clear, so no press is lost).
  - else clr & clr_mask[i]: 0.
  - else hold.
  - Clear takes effect the cycle after the clr strobe. clr with clr_mask = 0 is a no-op.
- Channels are fully independent. Simultaneous transitions on several keys produce simultaneous pulses.
- Reset mid-count: the counter is discarded and key_db returns to released. A key held through reset release is re-debounced and produces a fresh press_pulse.
- Counter never exceeds DEBOUNCE_CYCLES-1; no wrap-around is possible.

Decomposition:
- Shared package key_pkg:
  - DEFAULT_DEBOUNCE_CYCLES (1000000).
  - SIM_DEBOUNCE_CYCLES (8).
  - KEY_RELEASED constant (1'b1).
- Sub-module key_debounce_chan: one channel containing sync flops, counter, key_db bit, pulses and latch bit. It is replicated NUM_KEYS times via generate.
- The top level only fans out clr, clr_mask and the buses.

Test Plan:
All scenarios use DEBOUNCE_CYCLES=8, NUM_KEYS=4.
1. Reset:
   - Stimulus: reset_n low with key_raw=4'b0000.
   - Response: key_db=4'b1111, all pulses and latches 0.
   - After release with keys still held: press_pulse=4'b1111 exactly 10 cycles later; key_db=4'b0000.
2. Clean press:
   - Stimulus: key_raw[0] 1->0, held.
   - Response: key_db[0]=0 and press_pulse[0] high for 1 cycle at cycle 10; press_latch=4'b0001.
   - Then release: release_pulse[0] high for 1 cycle, 10 cycles later.
3. Bounce:
   - Stimulus: key_raw[1] low for 5 cycles, high 1 cycle, low 20 cycles.
   - Response: no pulse during the bounce; press_pulse[1] fires 10 cycles after the final falling edge; exactly one pulse total.
4. Clear handshake:
   - Stimulus: press_latch=4'b0011, then clr with clr_mask=4'b0001.
   - Response: press_latch=4'b0010 the next cycle.
   - Stimulus: clr with clr_mask=0.
   - Response: press_latch unchanged.
5. Set/clear collision:
   - Stimulus: clr with clr_mask=4'b0100 in the same cycle as press_pulse[2].
   - Response: press_latch[2] stays 1.
6. Simultaneous keys and reset mid-count:
   - Stimulus: keys 2 and 3 pressed on the same cycle.
   - Response: press_pulse=4'b1100 in a single cycle.
   - Stimulus: reset_n asserted at count 5 of a new press.
   - Response: key_db=4'b1111 immediately; no stale pulse after reset release.
